// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame
// clocked by the device, ACK sampling and a transfer timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_CYCLES  = 4
) (
  input  logic       CLK100MHZ,
  input  logic       ck_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK_WAIT, S_RELEASE
  } state_e;

  localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] RTS_LAST     = 32'(RTS_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  FILTER_LAST  = 8'(FILTER_CYCLES - 1);

  // Line index 0 is the PS/2 clock, index 1 the PS/2 data.
  logic [1:0]      meta_q, sync_q, filt_q, filt_d;
  logic [1:0][7:0] flt_cnt_q, flt_cnt_d;
  logic            clk_prev_q;
  logic            dev_fall;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      meta_q     <= {ps2_data_in, ps2_clk_in};
      sync_q     <= meta_q;
      filt_q     <= filt_d;
      clk_prev_q <= filt_q[0];
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != filt_q[i]) begin
        if (flt_cnt_q[i] == FILTER_LAST) filt_d[i] = sync_q[i];
        else flt_cnt_d[i] = flt_cnt_q[i] + 8'd1;
      end
    end
  end

  assign dev_fall = clk_prev_q && !filt_q[0];

  state_e      state_q, state_d;
  logic [31:0] phase_cnt_q, phase_cnt_d, to_cnt_q, to_cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic        clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic        done_q, done_d, ack_ok_q, ack_ok_d, err_q, err_d;
  logic        ready_en_q;
  logic        timed_out;

  // ready_en_q holds tx_ready low until the first edge after reset release.
  assign tx_ready    = ready_en_q && (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign timed_out   = (state_q == S_SEND || state_q == S_ACK_WAIT || state_q == S_RELEASE)
                       && (to_cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    to_cnt_d    = to_cnt_q;
    bit_d       = bit_q;
    data_d      = data_q;
    parity_d    = parity_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    ack_ok_d    = ack_ok_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          data_d      = tx_data;
          parity_d    = ~^tx_data;
          ack_ok_d    = 1'b0;
          err_d       = 1'b0;
          phase_cnt_d = '0;
          clk_oe_d    = 1'b1;
          data_oe_d   = 1'b0;
          state_d     = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (phase_cnt_q == INHIBIT_LAST) begin
          phase_cnt_d = '0;
          data_oe_d   = 1'b1;
          state_d     = S_RTS;
        end else phase_cnt_d = phase_cnt_q + 32'd1;
      end
      S_RTS: begin
        if (phase_cnt_q == RTS_LAST) begin
          clk_oe_d = 1'b0;
          to_cnt_d = '0;
          bit_d    = '0;
          state_d  = S_SEND;
        end else phase_cnt_d = phase_cnt_q + 32'd1;
      end
      S_SEND: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (dev_fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) data_oe_d = ~data_q[bit_q[2:0]];
          else if (bit_q == 4'd8) data_oe_d = ~parity_q;
          else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK_WAIT;
          end
        end
      end
      S_ACK_WAIT: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (dev_fall) begin
          ack_ok_d = ~filt_q[1];
          err_d    = filt_q[1];
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (filt_q == 2'b11) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The timeout overrides any device edge seen in the same cycle.
    if (timed_out) begin
      state_d   = S_IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      ack_ok_d  = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= '0;
      to_cnt_q    <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      ack_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      ack_ok_q    <= ack_ok_d;
      err_q       <= err_d;
      ready_en_q  <= 1'b1;
    end
  end

endmodule
